// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score controller.
// Points are packed BCD; every nibble must stay in 0..9.
package score_pkg;

  localparam int BCD_W     = 4;
  localparam int NDIGITS   = 4;
  localparam int DIG_IDX_W = 2;

  localparam logic [15:0] MAX_SCORE = 16'h9999;

  localparam logic [15:0] PTS1_DEF = 16'h0010;
  localparam logic [15:0] PTS2_DEF = 16'h0030;
  localparam logic [15:0] PTS3_DEF = 16'h0050;
  localparam logic [15:0] PTS4_DEF = 16'h0080;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ADD        = 2'd1,
    WAIT_FRAME = 2'd2
  } state_t;

  // Only 1..4 cleared lines earn points; other counts are swallowed.
  function automatic logic lines_num_ok(input logic [2:0] n);
    return (n >= 3'd1) && (n <= 3'd4);
  endfunction

endpackage

// File: rtl/score_ctrl_if.sv
// Line-clear event handshake from the game logic into the score controller.
interface score_ctrl_if;

  logic       lines_valid;
  logic [2:0] lines_num;
  logic       lines_ready;

  modport master (output lines_valid, output lines_num, input  lines_ready);
  modport slave  (input  lines_valid, input  lines_num, output lines_ready);

endinterface

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with carry in/out; shared across digits by the FSM.
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  localparam logic [BCD_W:0] RADIX = (BCD_W+1)'(10);

  logic [BCD_W:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    if (raw >= RADIX) begin
      sum  = BCD_W'(raw - RADIX);
      cout = 1'b1;
    end else begin
      sum  = raw[BCD_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/score_ctrl.sv
// BCD score accumulator: adds points one digit per cycle, commits to the
// display only on frame_start so the digit lookups never see a torn value.
module score_ctrl
  import score_pkg::*;
#(
  parameter logic [15:0] PTS1 = PTS1_DEF,
  parameter logic [15:0] PTS2 = PTS2_DEF,
  parameter logic [15:0] PTS3 = PTS3_DEF,
  parameter logic [15:0] PTS4 = PTS4_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_rst,
  input  logic               frame_start,
  score_ctrl_if.slave        evt,
  output logic [15:0]        score_out,
  output logic               score_pend,
  output logic               overflow
);

  state_t                 state_reg,  state_next;
  logic [15:0]            work_reg,   work_next;
  logic [15:0]            addend_reg, addend_next;
  logic                   carry_reg,  carry_next;
  logic [DIG_IDX_W-1:0]   digit_reg,  digit_next;
  logic [15:0]            score_reg,  score_next;
  logic                   pend_reg,   pend_next;
  logic                   ovf_reg,    ovf_next;

  logic                   lines_ready;
  logic                   accept_ok;
  logic [15:0]            pts_sel;
  logic [BCD_W-1:0]       dig_a, dig_b, dig_sum;
  logic                   dig_cout;
  logic [15:0]            work_add;

  // A frame_start in WAIT_FRAME takes the cycle for the commit.
  assign lines_ready     = (state_reg == IDLE) || ((state_reg == WAIT_FRAME) && !frame_start);
  assign evt.lines_ready = lines_ready;
  assign accept_ok       = evt.lines_valid && lines_ready && lines_num_ok(evt.lines_num);

  always_comb begin
    pts_sel = 16'h0000;
    case (evt.lines_num)
      3'd1:    pts_sel = PTS1;
      3'd2:    pts_sel = PTS2;
      3'd3:    pts_sel = PTS3;
      3'd4:    pts_sel = PTS4;
      default: pts_sel = 16'h0000;
    endcase
  end

  assign dig_a = work_reg[digit_reg*BCD_W +: BCD_W];
  assign dig_b = addend_reg[digit_reg*BCD_W +: BCD_W];

  bcd_digit_add u_digit_add (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_reg),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_work_wr
    assign work_add[gi*BCD_W +: BCD_W] =
        (digit_reg == DIG_IDX_W'(gi)) ? dig_sum : work_reg[gi*BCD_W +: BCD_W];
  end

  always_comb begin
    state_next  = state_reg;
    work_next   = work_reg;
    addend_next = addend_reg;
    carry_next  = carry_reg;
    digit_next  = digit_reg;
    score_next  = score_reg;
    pend_next   = pend_reg;
    ovf_next    = ovf_reg;

    if (game_rst) begin
      state_next = IDLE;
      work_next  = 16'h0000;
      carry_next = 1'b0;
      digit_next = '0;
      score_next = 16'h0000;
      pend_next  = 1'b0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept_ok) begin
            addend_next = pts_sel;
            digit_next  = '0;
            carry_next  = 1'b0;
            state_next  = ADD;
          end
        end
        ADD: begin
          work_next  = work_add;
          carry_next = dig_cout;
          digit_next = digit_reg + 1'b1;
          if (digit_reg == DIG_IDX_W'(NDIGITS-1)) begin
            state_next = WAIT_FRAME;
            pend_next  = 1'b1;
            if (dig_cout) begin
              work_next = MAX_SCORE;
              ovf_next  = 1'b1;
            end
          end
        end
        WAIT_FRAME: begin
          if (frame_start) begin
            score_next = work_reg;
            pend_next  = 1'b0;
            state_next = IDLE;
          end else if (accept_ok) begin
            addend_next = pts_sel;
            digit_next  = '0;
            carry_next  = 1'b0;
            state_next  = ADD;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      work_reg   <= 16'h0000;
      addend_reg <= 16'h0000;
      carry_reg  <= 1'b0;
      digit_reg  <= '0;
      score_reg  <= 16'h0000;
      pend_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      work_reg   <= work_next;
      addend_reg <= addend_next;
      carry_reg  <= carry_next;
      digit_reg  <= digit_next;
      score_reg  <= score_next;
      pend_reg   <= pend_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign score_out  = score_reg;
  assign score_pend = pend_reg;
  assign overflow   = ovf_reg;

endmodule

// File: tb/tb_score_ctrl.sv
// Randomized and directed bench for score_ctrl against a decimal-integer score model.
module tb_score_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_rst;
  logic        frame_start;
  logic [15:0] score_out;
  logic        score_pend;
  logic        overflow;

  score_ctrl_if evt ();

  score_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_rst    (game_rst),
    .frame_start (frame_start),
    .evt         (evt.slave),
    .score_out   (score_out),
    .score_pend  (score_pend),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: plain decimal integers for the working and displayed scores.
  int work_m  = 0;
  int score_m = 0;
  bit pend_m  = 0;
  bit ovf_m   = 0;

  function automatic int pts_of(input int n);
    case (n)
      1:       return 10;
      2:       return 30;
      3:       return 50;
      4:       return 80;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, wanted %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    check({tag, ".score"}, 32'(score_out), 32'(to_bcd(score_m)));
    check({tag, ".pend"},  32'(score_pend), 32'(pend_m));
    check({tag, ".ovf"},   32'(overflow),   32'(ovf_m));
  endtask

  task automatic model_clear();
    work_m = 0; score_m = 0; pend_m = 0; ovf_m = 0;
  endtask

  // Called at a negedge with the DUT in IDLE or WAIT_FRAME.
  task automatic do_event(input int n);
    evt.lines_valid = 1'b1;
    evt.lines_num   = 3'(n);
    #1 check("ready_accept", 32'(evt.lines_ready), 32'd1);
    @(negedge clk);
    evt.lines_valid = 1'b0;
    if (pts_of(n) != 0) begin
      work_m = work_m + pts_of(n);
      if (work_m > 9999) begin
        work_m = 9999;
        ovf_m  = 1;
      end
      check("ready_add", 32'(evt.lines_ready), 32'd0);
      repeat (3) @(negedge clk);
      check("ready_add_last", 32'(evt.lines_ready), 32'd0);
      @(negedge clk);
      pend_m = 1;
    end
    chk_outputs($sformatf("event%0d", n));
    check("ready_after", 32'(evt.lines_ready), 32'd1);
    $display("event lines_num=%0d work=%0d score_out=%h pend=%0b ovf=%0b",
             n, work_m, score_out, score_pend, overflow);
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    #1 check("ready_frame", 32'(evt.lines_ready), pend_m ? 32'd0 : 32'd1);
    @(negedge clk);
    frame_start = 1'b0;
    if (pend_m) begin
      score_m = work_m;
      pend_m  = 0;
    end
    chk_outputs("frame");
    $display("frame score_out=%h pend=%0b", score_out, score_pend);
  endtask

  task automatic do_game_rst();
    game_rst = 1'b1;
    @(negedge clk);
    game_rst = 1'b0;
    model_clear();
    chk_outputs("game_rst");
    check("ready_game_rst", 32'(evt.lines_ready), 32'd1);
    $display("game_rst score_out=%h", score_out);
  endtask

  // Requires pending work: commit and event collide in WAIT_FRAME.
  task automatic do_collision(input int n);
    frame_start     = 1'b1;
    evt.lines_valid = 1'b1;
    evt.lines_num   = 3'(n);
    #1 check("ready_collide", 32'(evt.lines_ready), 32'd0);
    @(negedge clk);
    frame_start = 1'b0;
    score_m = work_m;
    pend_m  = 0;
    chk_outputs("collide_commit");
    $display("collision commit score_out=%h", score_out);
    do_event(n);
  endtask

  task automatic do_idle();
    @(negedge clk);
    chk_outputs("idle");
    $display("idle score_out=%h pend=%0b", score_out, score_pend);
  endtask

  initial begin
    rst_n           = 1'b0;
    game_rst        = 1'b0;
    frame_start     = 1'b0;
    evt.lines_valid = 1'b0;
    evt.lines_num   = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_outputs("reset");
    check("ready_reset", 32'(evt.lines_ready), 32'd1);

    // Single event; frame arrives five cycles after pend rises.
    do_event(1);
    repeat (4) do_idle();
    do_frame();

    // Reset asserted mid-add.
    do_event(2);
    do_frame();
    evt.lines_valid = 1'b1;
    evt.lines_num   = 3'd3;
    @(negedge clk);
    evt.lines_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk_outputs("async_reset");
    check("ready_async_reset", 32'(evt.lines_ready), 32'd1);
    $display("async reset score_out=%h", score_out);
    @(negedge clk);
    rst_n = 1'b1;

    // Carry chains: 0070+0080 and 0990+0010.
    do_event(3); do_event(1); do_event(1); do_frame();
    do_event(4); do_frame();
    do_game_rst();
    for (int i = 0; i < 12; i++) do_event(4);
    do_event(2);
    do_frame();
    do_event(1);
    do_frame();

    // Accumulate two events into one commit.
    do_game_rst();
    do_event(2);
    do_event(3);
    do_idle();
    do_frame();

    // Collision of commit and event.
    do_event(1);
    do_collision(1);
    do_frame();

    // Ignored line counts, in IDLE and in WAIT_FRAME.
    do_event(0);
    do_event(7);
    do_event(2);
    do_event(5);
    do_frame();

    // game_rst aborting an add.
    do_event(4);
    do_frame();
    evt.lines_valid = 1'b1;
    evt.lines_num   = 3'd4;
    @(negedge clk);
    evt.lines_valid = 1'b0;
    do_game_rst();
    repeat (5) do_idle();
    do_event(1);
    do_frame();

    // Saturation from 9950.
    do_game_rst();
    for (int i = 0; i < 124; i++) do_event(4);
    do_event(2);
    do_frame();
    do_event(4);
    do_frame();
    do_event(1);
    do_frame();
    do_game_rst();

    // Randomized mix.
    for (int k = 0; k < 300; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 45)                do_event(int'($urandom_range(0, 7)));
      else if (r < 55 && pend_m) do_collision(int'($urandom_range(1, 4)));
      else if (r < 78)           do_frame();
      else if (r < 96)           do_idle();
      else                       do_game_rst();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
